// File: rtl/demux1x2_stream.sv
// Stream 1-to-2 demux with valid/ready handshake: the destination is sampled on
// the first beat of a burst and locked until the in_last beat. Each output is registered.
module demux1x2_stream #(
  parameter int DATAWIDTH = 2,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] d,
  input  logic                 sel,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] q0,
  output logic [DATAWIDTH-1:0] q1,
  output logic                 q0_valid,
  output logic                 q1_valid,
  output logic                 q0_last,
  output logic                 q1_last,
  input  logic                 q0_ready,
  input  logic                 q1_ready,
  output logic [CNTWIDTH-1:0]  cnt0,
  output logic [CNTWIDTH-1:0]  cnt1
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                          state_q, state_d;
  logic [1:0][DATAWIDTH-1:0]       q_q, q_d;
  logic [1:0]                      vld_q, vld_d, last_q, last_d, rdy;
  logic [1:0][CNTWIDTH-1:0]        cnt_q, cnt_d;
  logic                            dst, acc;

  assign rdy = {q1_ready, q0_ready};

  always_comb begin
    dst = sel;
    if (state_q == LOCK0) dst = 1'b0;
    else if (state_q == LOCK1) dst = 1'b1;
  end

  // Only the selected output's handshake may gate the input.
  assign in_ready = !vld_q[dst] || rdy[dst];
  assign acc      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (acc) begin
      if (state_q == IDLE) begin
        if (!in_last) state_d = sel ? LOCK1 : LOCK0;
      end else if (in_last) begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    q_d    = q_q;
    vld_d  = vld_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    for (int x = 0; x < 2; x++) begin
      if (acc && (dst == x[0])) begin
        q_d[x]    = d;
        last_d[x] = in_last;
        vld_d[x]  = 1'b1;
        cnt_d[x]  = cnt_q[x] + 1'b1;
      end else if (rdy[x]) begin
        vld_d[x] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      vld_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q0       = q_q[0];
  assign q1       = q_q[1];
  assign q0_valid = vld_q[0];
  assign q1_valid = vld_q[1];
  assign q0_last  = last_q[0];
  assign q1_last  = last_q[1];
  assign cnt0     = cnt_q[0];
  assign cnt1     = cnt_q[1];

endmodule

// File: doc/demux1x2_stream.md
# demux1x2_stream

Stream-level 1-to-2 demultiplexer with valid/ready handshaking and burst locking. A single input stream is routed to one of two registered output channels; `sel` is sampled on the first beat of each burst and held until the beat carrying `in_last`. The block sits in the datapath wherever a combinational 2x1 select must be reversed, fanning one producer out to two consumers. It also provides per-output beat counters for debug.

## Interface
- `DATAWIDTH`, 2, width of data on the input and both outputs.
- `CNTWIDTH`, 8, width of each per-output beat counter.

- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: asynchronous, active-low reset. Asserts immediately, releases synchronously to `Clk`.
- `d` in DATAWIDTH: input data.
- `sel` in 1: destination select (0 routes to `q0`, 1 routes to `q1`). Sampled only on the first beat of a burst.
- `in_valid` in 1: input beat valid.
- `in_last` in 1: marks the final beat of a burst.
- `in_ready` out 1: input beat accepted this cycle when `in_valid && in_ready`.
- `q0`, `q1` out DATAWIDTH: registered output data.
- `q0_valid`, `q1_valid` out 1: output beat valid.
- `q0_last`, `q1_last` out 1: registered copy of `in_last` for that beat.
- `q0_ready`, `q1_ready` in 1: downstream accept signals.
- `cnt0`, `cnt1` out CNTWIDTH: beats accepted toward each output.

## Operation
- **States:**
  - `IDLE`: no burst is open.
  - `LOCK0`: a burst is open to output 0.
  - `LOCK1`: a burst is open to output 1.
- **Destination:** `dst = sel` in `IDLE`. In `LOCK0` it is 0, and in `LOCK1` it is 1; `sel` is ignored in both lock states.
- **Accept:** `acc = in_valid && in_ready`.
- **Ready:** `in_ready = !q<dst>_valid || q<dst>_ready`. It is combinational from state, `sel`, and the selected output's handshake only. The non-selected output never affects `in_ready`.
- **State transitions, on `acc`:**
  - `IDLE`: if `!in_last`, go to `LOCK<sel>`; otherwise stay in `IDLE` (single-beat burst).
  - `LOCKx`: if `in_last`, go to `IDLE`; otherwise stay in `LOCKx`.
  - With no `acc`, the state holds. A gap in `in_valid` mid-burst keeps the lock.
- **Output register x, each cycle:**
  - If `acc && dst==x`, load `qx <= d`, `qx_last <= in_last`, `qx_valid <= 1`.
  - Else if `qx_ready`, set `qx_valid <= 0`.
  - Else hold.
  - `qx` and `qx_last` are held stable while `qx_valid && !qx_ready`.
- **Counters:** `cntx` increments by 1 on each `acc` with `dst==x`. It wraps modulo 2^CNTWIDTH with no saturation.
- **Ordering:** beats are never duplicated, dropped (except by reset), or reordered within an output.

## Timing
- **Reset values:** all outputs are 0, meaning `q0`, `q1`, all `*_valid`, all `*_last`, `cnt0`, and `cnt1`. State is `IDLE`.
- **Latency:** an accepted beat appears on `qx`/`qx_valid` exactly 1 cycle after the accepting edge.
- **Throughput:** 1 beat per cycle when the target's ready is held high.
- **Full output register:** when `qx_valid=1` and `qx_ready=0`, `in_ready=0` for beats targeting x. Beats targeting the other output, in `IDLE` with the other `sel`, still flow.
- **Simultaneous drain and load:** in the same cycle, the load wins and `qx_valid` stays 1 with the new data.
- **Reset mid-burst:** held output beats are discarded, the lock is cleared, and counters clear. The next accepted beat is treated as a burst start.
- **`sel` toggling inside a burst:** no effect on routing.

## Test plan
- **Reset:** assert `Rst=0` mid-burst while `q1_valid=1` → all outputs 0 and state `IDLE`. After release, a beat with `sel=0`, `d=2'b01`, `in_last=1` appears on `q0=2'b01` one cycle later.
- **Burst lock:** 4-beat burst `d=0,1,2,3` with `sel=1` on beat 0 and `sel=0` on beats 1–3; `in_last` on beat 3 → all four beats on `q1` in order, with `q1_last` only on beat 3. `q0_valid` stays 0, `cnt1=4`, `cnt0=0`.
- **Backpressure:** `q0_ready=0` with a beat held on `q0` → `in_ready=0` for `sel=0`. Beats with `sel=1` in `IDLE` pass to `q1`. Raising `q0_ready` then drains `q0` and restores `in_ready`.
- **Streaming:** `q1_ready` held 1 and 10 back-to-back single-beat transfers to `q1` → one beat per cycle, `in_ready` stays 1 throughout, `cnt1=10`.
- **Counter wrap:** with `CNTWIDTH=2`, 5 beats to `q0` → `cnt0=1`.
- **Valid gap:** `in_valid` drops for 3 cycles mid-burst in `LOCK0` while `sel=1` → the next beat still goes to `q0`.
